// File: rtl/axi_read_if.sv
// AXI-style read channel bundle (AR + R) shared by the requesters and the
// memory slave. The master modport issues addresses and accepts data; the
// slave modport accepts addresses and returns data.
interface axi_read_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic                  arvalid;
    logic                  arready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;
    logic                  rlast;

    modport master (
        output araddr, arlen, arvalid, rready,
        input  arready, rdata, rresp, rvalid, rlast
    );

    modport slave (
        input  araddr, arlen, arvalid, rready,
        output arready, rdata, rresp, rvalid, rlast
    );
endinterface

// File: rtl/axi_read_arbiter.sv
// Two-requester, one-slave read arbiter. One whole burst is granted at a time
// with round-robin priority; address and length are held in registers from
// the grant until the last beat so the memory can sample arlen at any point.
//
// Handshake rule on every AR and R channel: a transfer happens on a rising
// edge where valid and ready are both high; valid, once raised, is held with
// stable payload until that transfer (except that a requester may withdraw an
// ungranted arvalid, which simply forfeits the request).
module axi_read_arbiter #(
    parameter int   ADDR_WIDTH   = 32,   // matches the RISC-V core address width
    parameter logic RR_RESET_PTR = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    axi_read_if.slave  m0_if,
    axi_read_if.slave  m1_if,
    axi_read_if.master mem_if,
    output logic       busy,
    output logic       grant_id,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2
    } state_t;

    state_t                state;
    state_t                next_state;
    logic                  rr_ptr;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic                  winner;
    logic                  grant_fire;
    logic                  last_fire;

    // With both requesting the pointer decides; otherwise whoever asks wins.
    assign winner = (m0_if.arvalid && m1_if.arvalid) ? rr_ptr : m1_if.arvalid;

    // The memory sees the latched request in every state.
    assign mem_if.araddr = addr_q;
    assign mem_if.arlen  = len_q;

    assign busy      = (state != IDLE);
    assign dbg_state = state;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state, arbitration, and combinational R-channel routing.
    always_comb begin
        next_state     = state;
        grant_fire     = 1'b0;
        last_fire      = 1'b0;
        m0_if.arready  = 1'b0;
        m1_if.arready  = 1'b0;
        m0_if.rvalid   = 1'b0;
        m0_if.rdata    = 32'd0;
        m0_if.rresp    = 2'b00;
        m0_if.rlast    = 1'b0;
        m1_if.rvalid   = 1'b0;
        m1_if.rdata    = 32'd0;
        m1_if.rresp    = 2'b00;
        m1_if.rlast    = 1'b0;
        mem_if.arvalid = 1'b0;
        mem_if.rready  = 1'b0;
        unique case (state)
            IDLE: begin
                if (m0_if.arvalid || m1_if.arvalid) begin
                    grant_fire = 1'b1;
                    next_state = AR;
                    if (winner) begin
                        m1_if.arready = 1'b1;
                    end else begin
                        m0_if.arready = 1'b1;
                    end
                end
            end
            AR: begin
                mem_if.arvalid = 1'b1;
                if (mem_if.arready) begin
                    next_state = R;
                end
            end
            R: begin
                if (grant_id) begin
                    m1_if.rvalid  = mem_if.rvalid;
                    m1_if.rdata   = mem_if.rdata;
                    m1_if.rresp   = mem_if.rresp;
                    m1_if.rlast   = mem_if.rlast;
                    mem_if.rready = m1_if.rready;
                    last_fire     = mem_if.rvalid && m1_if.rready && mem_if.rlast;
                end else begin
                    m0_if.rvalid  = mem_if.rvalid;
                    m0_if.rdata   = mem_if.rdata;
                    m0_if.rresp   = mem_if.rresp;
                    m0_if.rlast   = mem_if.rlast;
                    mem_if.rready = m0_if.rready;
                    last_fire     = mem_if.rvalid && m0_if.rready && mem_if.rlast;
                end
                if (last_fire) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Capture the granted request and advance the pointer at burst end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            len_q    <= 8'd0;
            grant_id <= 1'b0;
            rr_ptr   <= RR_RESET_PTR;
        end else begin
            if (grant_fire) begin
                addr_q   <= winner ? m1_if.araddr : m0_if.araddr;
                len_q    <= winner ? m1_if.arlen  : m0_if.arlen;
                grant_id <= winner;
            end
            if (last_fire) begin
                rr_ptr <= ~grant_id;
            end
        end
    end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: a behavioural memory slave returns
// word = address + 4*beat, monitors record grants and beats per requester,
// and each scenario task compares them against hand-written expectations.
module tb_axi_read_arbiter;
    localparam int AW = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       busy;
    logic       grant_id;
    logic [1:0] dbg_state;

    int total = 0;
    int bad   = 0;

    axi_read_if #(.ADDR_WIDTH(AW)) m0_if ();
    axi_read_if #(.ADDR_WIDTH(AW)) m1_if ();
    axi_read_if #(.ADDR_WIDTH(AW)) mem_if ();

    axi_read_arbiter #(.ADDR_WIDTH(AW), .RR_RESET_PTR(1'b0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m0_if     (m0_if),
        .m1_if     (m1_if),
        .mem_if    (mem_if),
        .busy      (busy),
        .grant_id  (grant_id),
        .dbg_state (dbg_state)
    );

    // Clock.
    always #5 clk = ~clk;

    // Memory slave model: one burst at a time, rlast from the live arlen.
    logic        mem_act;
    logic [31:0] mem_base;
    logic [7:0]  mem_cnt;
    assign mem_if.arready = !mem_act;
    assign mem_if.rvalid  = mem_act;
    assign mem_if.rdata   = mem_base + {22'd0, mem_cnt, 2'b00};
    assign mem_if.rresp   = 2'b00;
    assign mem_if.rlast   = mem_act && (mem_cnt == mem_if.arlen);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_act  <= 1'b0;
            mem_base <= 32'd0;
            mem_cnt  <= 8'd0;
        end else if (!mem_act) begin
            if (mem_if.arvalid) begin
                mem_act  <= 1'b1;
                mem_base <= mem_if.araddr;
                mem_cnt  <= 8'd0;
            end
        end else if (mem_if.rready) begin
            if (mem_cnt == mem_if.arlen) mem_act <= 1'b0;
            else mem_cnt <= mem_cnt + 8'd1;
        end
    end

    // Monitors: grant order and accepted beats {rlast, rdata}.
    logic        grant_q[$];
    logic [32:0] beat0_q[$];
    logic [32:0] beat1_q[$];
    logic [32:0] exp_q[$];
    int g0_cnt = 0;
    int g1_cnt = 0;

    always @(posedge clk) begin
        if (rst_n) begin
            if (m0_if.arvalid && m0_if.arready) begin grant_q.push_back(1'b0); g0_cnt++; end
            if (m1_if.arvalid && m1_if.arready) begin grant_q.push_back(1'b1); g1_cnt++; end
            if (m0_if.rvalid && m0_if.rready) beat0_q.push_back({m0_if.rlast, m0_if.rdata});
            if (m1_if.rvalid && m1_if.rready) beat1_q.push_back({m1_if.rlast, m1_if.rdata});
        end
    end

    // Driver tasks.
    task automatic clear_logs();
        grant_q.delete(); beat0_q.delete(); beat1_q.delete(); exp_q.delete();
        g0_cnt = 0; g1_cnt = 0;
    endtask

    task automatic idle_inputs();
        m0_if.araddr = '0; m0_if.arlen = 8'd0; m0_if.arvalid = 1'b0; m0_if.rready = 1'b0;
        m1_if.araddr = '0; m1_if.arlen = 8'd0; m1_if.arvalid = 1'b0; m1_if.rready = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        clear_logs();
    endtask

    task automatic wait_idle(input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin timed_out = 1'b0; break; end
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
        total++; if (grant_id !== 1'b0) begin bad++; $display("FAIL reset_grant_id: got %0b want 0", grant_id); end
        total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
        total++; if (mem_if.arvalid !== 1'b0 || mem_if.rready !== 1'b0) begin bad++; $display("FAIL reset_mem_ctl: arvalid %0b rready %0b want 0 0", mem_if.arvalid, mem_if.rready); end
        total++; if (mem_if.araddr !== 32'd0 || mem_if.arlen !== 8'd0) begin bad++; $display("FAIL reset_addr_len: got %0h/%0h want 0/0", mem_if.araddr, mem_if.arlen); end
        total++; if (m0_if.rvalid !== 1'b0 || m1_if.rvalid !== 1'b0 || m0_if.rdata !== 32'd0 || m0_if.rlast !== 1'b0) begin bad++; $display("FAIL reset_master_r: rvalid %0b/%0b rdata %0h", m0_if.rvalid, m1_if.rvalid, m0_if.rdata); end
        @(negedge clk);
        rst_n = 1'b1;
        clear_logs();
    endtask

    task automatic test_single_m0();
        bit to;
        clear_logs();
        @(negedge clk);
        m0_if.araddr = 32'h10; m0_if.arlen = 8'd0; m0_if.arvalid = 1'b1; m0_if.rready = 1'b1;
        #1;
        total++; if (m0_if.arready !== 1'b1 || m1_if.arready !== 1'b0) begin bad++; $display("FAIL single_arready: m0 %0b m1 %0b want 1 0", m0_if.arready, m1_if.arready); end
        @(negedge clk);
        total++; if (busy !== 1'b1 || grant_id !== 1'b0) begin bad++; $display("FAIL single_ar_state: busy %0b grant %0b want 1 0", busy, grant_id); end
        total++; if (mem_if.arvalid !== 1'b1 || mem_if.araddr !== 32'h10) begin bad++; $display("FAIL single_mem_ar: arvalid %0b araddr %0h want 1 10", mem_if.arvalid, mem_if.araddr); end
        total++; if (m0_if.arready !== 1'b0) begin bad++; $display("FAIL single_arready_drop: got %0b want 0", m0_if.arready); end
        m0_if.arvalid = 1'b0;
        wait_idle(20, to);
        total++; if (to) begin bad++; $display("FAIL single_timeout: busy %0b want 0", busy); end
        total++; if (beat0_q.size() != 1 || beat0_q[0] !== {1'b1, 32'h10}) begin bad++; $display("FAIL single_beat: count %0d want 1", beat0_q.size()); end
        total++; if (dut.rr_ptr !== 1'b1) begin bad++; $display("FAIL single_rr_ptr: got %0b want 1", dut.rr_ptr); end
    endtask

    task automatic test_m1_burst();
        bit started = 1'b0;
        int errs = 0;
        clear_logs();
        @(negedge clk);
        m1_if.araddr = 32'h20; m1_if.arlen = 8'd3; m1_if.arvalid = 1'b1; m1_if.rready = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (busy) begin
                started = 1'b1;
                m1_if.arvalid = 1'b0;
                if (m0_if.rvalid !== 1'b0 || mem_if.arlen !== 8'd3) errs++;
            end else if (started) begin
                break;
            end
            m1_if.rready = (cyc % 2 == 1);
        end
        m1_if.rready = 1'b0;
        total++; if (!started || busy) begin bad++; $display("FAIL burst_timeout: started %0b busy %0b", started, busy); end
        total++; if (errs != 0) begin bad++; $display("FAIL burst_isolation: bad cycles %0d want 0", errs); end
        exp_q = '{{1'b0, 32'h20}, {1'b0, 32'h24}, {1'b0, 32'h28}, {1'b1, 32'h2C}};
        total++; if (beat1_q.size() != 4) begin bad++; $display("FAIL burst_count: got %0d want 4", beat1_q.size()); end
        while (exp_q.size() != 0 && beat1_q.size() != 0) begin
            logic [32:0] e, g;
            e = exp_q.pop_front(); g = beat1_q.pop_front();
            total++; if (g !== e) begin bad++; $display("FAIL burst_beat: got %0h want %0h", g, e); end
        end
        total++; if (beat0_q.size() != 0) begin bad++; $display("FAIL burst_m0_beats: got %0d want 0", beat0_q.size()); end
        total++; if (dut.rr_ptr !== 1'b0) begin bad++; $display("FAIL burst_rr_ptr: got %0b want 0", dut.rr_ptr); end
    endtask

    task automatic test_simultaneous();
        bit done = 1'b0;
        apply_reset();
        m0_if.araddr = 32'h100; m0_if.arlen = 8'd1; m0_if.rready = 1'b1;
        m1_if.araddr = 32'h200; m1_if.arlen = 8'd1; m1_if.rready = 1'b1;
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(negedge clk);
            m0_if.arvalid = (g0_cnt < 2);
            m1_if.arvalid = (g1_cnt < 1);
            if (g0_cnt == 2 && g1_cnt == 1 && !busy) begin done = 1'b1; break; end
        end
        m0_if.arvalid = 1'b0; m1_if.arvalid = 1'b0;
        total++; if (!done) begin bad++; $display("FAIL simul_timeout: grants %0d/%0d want 2/1", g0_cnt, g1_cnt); end
        total++; if (grant_q.size() != 3) begin bad++; $display("FAIL simul_grants: got %0d want 3", grant_q.size()); end
        else begin
            total++; if (grant_q[0] !== 1'b0 || grant_q[1] !== 1'b1 || grant_q[2] !== 1'b0) begin bad++; $display("FAIL simul_order: got %0b%0b%0b want 010", grant_q[0], grant_q[1], grant_q[2]); end
        end
        total++; if (beat1_q.size() != 2 || beat1_q[1] !== {1'b1, 32'h204}) begin bad++; $display("FAIL simul_m1_beats: count %0d want 2", beat1_q.size()); end
        total++; if (beat0_q.size() != 4) begin bad++; $display("FAIL simul_m0_beats: got %0d want 4", beat0_q.size()); end
        total++; if (dut.rr_ptr !== 1'b1) begin bad++; $display("FAIL simul_rr_ptr: got %0b want 1", dut.rr_ptr); end
    endtask

    task automatic test_busy_request();
        bit saw = 1'b0;
        bit to;
        int errs = 0;
        clear_logs();
        @(negedge clk);
        m1_if.araddr = 32'h30; m1_if.arlen = 8'd3; m1_if.arvalid = 1'b1; m1_if.rready = 1'b1;
        m0_if.rready = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (busy && grant_id) begin
                if (m0_if.arready !== 1'b0 || mem_if.araddr !== 32'h30) errs++;
                m1_if.arvalid = 1'b0;
                if (dbg_state == 2'd2) begin
                    m0_if.araddr = 32'h40; m0_if.arlen = 8'd0; m0_if.arvalid = 1'b1;
                end
            end else if (!busy && m0_if.arvalid) begin
                saw = 1'b1;
                total++; if (m0_if.arready !== 1'b1) begin bad++; $display("FAIL busy_grant_after: m0 arready %0b want 1", m0_if.arready); end
                break;
            end
        end
        total++; if (!saw) begin bad++; $display("FAIL busy_timeout: m0 never reached IDLE grant, busy %0b", busy); end
        total++; if (errs != 0) begin bad++; $display("FAIL busy_hold: bad cycles %0d want 0", errs); end
        @(negedge clk);
        m0_if.arvalid = 1'b0;
        total++; if (grant_id !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL busy_m0_granted: grant %0b busy %0b want 0 1", grant_id, busy); end
        wait_idle(20, to);
        total++; if (to || beat0_q.size() != 1 || beat0_q[0] !== {1'b1, 32'h40}) begin bad++; $display("FAIL busy_m0_beat: count %0d timeout %0b", beat0_q.size(), to); end
        total++; if (beat1_q.size() != 4) begin bad++; $display("FAIL busy_m1_beats: got %0d want 4", beat1_q.size()); end
    endtask

    task automatic test_reset_mid();
        bit hit = 1'b0;
        bit to;
        clear_logs();
        @(negedge clk);
        m0_if.araddr = 32'h50; m0_if.arlen = 8'd3; m0_if.arvalid = 1'b1; m0_if.rready = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (busy) m0_if.arvalid = 1'b0;
            if (beat0_q.size() == 1) begin hit = 1'b1; break; end
        end
        total++; if (!hit || m0_if.rvalid !== 1'b1) begin bad++; $display("FAIL mid_second_beat: hit %0b rvalid %0b want 1 1", hit, m0_if.rvalid); end
        rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || dbg_state !== 2'd0) begin bad++; $display("FAIL mid_async_state: busy %0b state %0d want 0 0", busy, dbg_state); end
        total++; if (m0_if.rvalid !== 1'b0 || m0_if.rdata !== 32'd0 || m0_if.rlast !== 1'b0) begin bad++; $display("FAIL mid_async_r: rvalid %0b rdata %0h", m0_if.rvalid, m0_if.rdata); end
        total++; if (mem_if.rready !== 1'b0 || mem_if.araddr !== 32'd0 || mem_if.arlen !== 8'd0) begin bad++; $display("FAIL mid_async_mem: rready %0b araddr %0h arlen %0h", mem_if.rready, mem_if.araddr, mem_if.arlen); end
        @(negedge clk);
        rst_n = 1'b1;
        clear_logs();
        m1_if.araddr = 32'h60; m1_if.arlen = 8'd0; m1_if.arvalid = 1'b1; m1_if.rready = 1'b1;
        @(negedge clk);
        m1_if.arvalid = 1'b0;
        total++; if (grant_id !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL mid_regrant: grant %0b busy %0b want 1 1", grant_id, busy); end
        wait_idle(20, to);
        total++; if (to || beat1_q.size() != 1 || beat1_q[0] !== {1'b1, 32'h60}) begin bad++; $display("FAIL mid_regrant_beat: count %0d timeout %0b", beat1_q.size(), to); end
    endtask

    task automatic test_withdraw();
        int busy_cnt = 0;
        int errs = 0;
        clear_logs();
        @(negedge clk);
        m0_if.araddr = 32'h70; m0_if.arlen = 8'd3; m0_if.arvalid = 1'b1; m0_if.rready = 1'b1;
        m1_if.araddr = 32'h80; m1_if.arlen = 8'd0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (m1_if.arready !== 1'b0) errs++;
            if (!busy) break;
            busy_cnt++;
            m0_if.arvalid = 1'b0;
            if (busy_cnt == 2) m1_if.arvalid = 1'b1;
            if (busy_cnt == 4) m1_if.arvalid = 1'b0;
        end
        total++; if (busy_cnt != 5) begin bad++; $display("FAIL withdraw_burst_len: busy cycles %0d want 5", busy_cnt); end
        total++; if (errs != 0) begin bad++; $display("FAIL withdraw_arready: bad cycles %0d want 0", errs); end
        total++; if (dut.rr_ptr !== 1'b1) begin bad++; $display("FAIL withdraw_rr_ptr: got %0b want 1", dut.rr_ptr); end
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0 || grant_q.size() != 1 || g1_cnt != 0) begin bad++; $display("FAIL withdraw_no_grant: busy %0b grants %0d m1 %0d want 0 1 0", busy, grant_q.size(), g1_cnt); end
    endtask

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        test_reset();
        test_single_m0();
        test_m1_burst();
        test_simultaneous();
        test_busy_request();
        test_reset_mid();
        test_withdraw();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
